// File: rtl/res_station_multi.sv
// Multi-entry reservation station: buffers issued ops, snoops CDB ports, dispatches one ready op per cycle.
// Optional RS_AGE_ORDER_EN: oldest-ready selection via per-entry age masks; otherwise lowest-index ready.
module res_station_multi #(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  in_op,
    input  logic [2:0]                  in_funct3,
    input  logic [6:0]                  in_funct7,
    input  logic [TAG_W-1:0]            in_src1_tag,
    input  logic [DATA_W-1:0]           in_src1_data,
    input  logic                        in_src1_valid,
    input  logic [TAG_W-1:0]            in_src2_tag,
    input  logic [DATA_W-1:0]           in_src2_data,
    input  logic                        in_src2_valid,
    input  logic [TAG_W-1:0]            in_rd_tag,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [6:0]                  issue_op,
    output logic [2:0]                  issue_funct3,
    output logic [6:0]                  issue_funct7,
    output logic [DATA_W-1:0]           issue_src1,
    output logic [DATA_W-1:0]           issue_src2,
    output logic [TAG_W-1:0]            issue_rd_tag,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [6:0]        op;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_data;
        logic              s1_v;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_data;
        logic              s2_v;
        logic [TAG_W-1:0]  rd_tag;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  rdy;
    logic [IDX_W-1:0]  sel_idx, free_idx;
    logic              any_rdy, any_free;
    logic              do_alloc, do_issue;
    logic [DATA_W:0]   wk1 [DEPTH];
    logic [DATA_W:0]   wk2 [DEPTH];
    logic [DATA_W:0]   byp1, byp2;
`ifdef RS_AGE_ORDER_EN
    logic [DEPTH-1:0]  older_q [DEPTH];
    logic [DEPTH-1:0]  older_d [DEPTH];
`endif

    // {hit, data}; lowest-index matching port wins
    function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag,
                                              input logic [NUM_CDB-1:0] v,
                                              input logic [NUM_CDB*TAG_W-1:0] tags,
                                              input logic [NUM_CDB*DATA_W-1:0] datas);
        snoop = '0;
        for (int unsigned p = 0; p < NUM_CDB; p++) begin
            if (!snoop[DATA_W] && v[p] && tags[p*TAG_W +: TAG_W] == tag)
                snoop = {1'b1, datas[p*DATA_W +: DATA_W]};
        end
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wk1[i] = snoop(ent_q[i].s1_tag, cdb_valid, cdb_tag, cdb_data);
            wk2[i] = snoop(ent_q[i].s2_tag, cdb_valid, cdb_tag, cdb_data);
        end
        byp1 = snoop(in_src1_tag, cdb_valid, cdb_tag, cdb_data);
        byp2 = snoop(in_src2_tag, cdb_valid, cdb_tag, cdb_data);
    end

    always_comb begin
        sel_idx  = '0;
        any_rdy  = 1'b0;
        free_idx = '0;
        any_free = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++)
            rdy[i] = vld_q[i] & ent_q[i].s1_v & ent_q[i].s2_v;
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef RS_AGE_ORDER_EN
            if (!any_rdy && rdy[i] && (older_q[i] & rdy) == '0) begin
`else
            if (!any_rdy && rdy[i]) begin
`endif
                sel_idx = IDX_W'(i);
                any_rdy = 1'b1;
            end
            if (!any_free && !vld_q[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready     = count_q < CNT_W'(DEPTH);
        count        = count_q;
        issue_valid  = any_rdy;
        issue_op     = '0;
        issue_funct3 = '0;
        issue_funct7 = '0;
        issue_src1   = '0;
        issue_src2   = '0;
        issue_rd_tag = '0;
        if (any_rdy) begin
            issue_op     = ent_q[sel_idx].op;
            issue_funct3 = ent_q[sel_idx].f3;
            issue_funct7 = ent_q[sel_idx].f7;
            issue_src1   = ent_q[sel_idx].s1_data;
            issue_src2   = ent_q[sel_idx].s2_data;
            issue_rd_tag = ent_q[sel_idx].rd_tag;
        end
    end

    always_comb begin
        ent_d    = ent_q;
        vld_d    = vld_q;
        do_issue = any_rdy & issue_ready;
        do_alloc = in_valid & in_ready & any_free;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !ent_q[i].s1_v && wk1[i][DATA_W]) begin
                ent_d[i].s1_v    = 1'b1;
                ent_d[i].s1_data = wk1[i][DATA_W-1:0];
            end
            if (vld_q[i] && !ent_q[i].s2_v && wk2[i][DATA_W]) begin
                ent_d[i].s2_v    = 1'b1;
                ent_d[i].s2_data = wk2[i][DATA_W-1:0];
            end
        end
        if (do_issue)
            vld_d[sel_idx] = 1'b0;
        if (do_alloc) begin
            ent_d[free_idx].op      = in_op;
            ent_d[free_idx].f3      = in_funct3;
            ent_d[free_idx].f7      = in_funct7;
            ent_d[free_idx].s1_tag  = in_src1_tag;
            ent_d[free_idx].s1_v    = in_src1_valid | byp1[DATA_W];
            ent_d[free_idx].s1_data = in_src1_valid ? in_src1_data : byp1[DATA_W-1:0];
            ent_d[free_idx].s2_tag  = in_src2_tag;
            ent_d[free_idx].s2_v    = in_src2_valid | byp2[DATA_W];
            ent_d[free_idx].s2_data = in_src2_valid ? in_src2_data : byp2[DATA_W-1:0];
            ent_d[free_idx].rd_tag  = in_rd_tag;
            vld_d[free_idx]         = 1'b1;
        end
        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_issue);
        if (flush) begin
            vld_d   = '0;
            count_d = '0;
        end
    end

`ifdef RS_AGE_ORDER_EN
    // A new entry is older than nobody; everything still resident is older than it.
    // Stale bits of freed entries are masked by rdy and cleared when that slot is reused.
    always_comb begin
        older_d = older_q;
        if (do_alloc) begin
            for (int unsigned j = 0; j < DEPTH; j++)
                older_d[j][free_idx] = 1'b0;
            older_d[free_idx] = vld_q;
            if (do_issue)
                older_d[free_idx][sel_idx] = 1'b0;
        end
        if (flush) begin
            for (int unsigned j = 0; j < DEPTH; j++)
                older_d[j] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned j = 0; j < DEPTH; j++)
                older_q[j] <= '0;
        end else begin
            older_q <= older_d;
        end
    end
`else
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_res_station_multi.sv
// Directed bench for res_station_multi: sequence-number reference model checked every cycle plus literal checks.
module tb_res_station_multi;
    localparam int DEPTH = 4;
    localparam int NCDB  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_op = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [2:0]  in_src1_tag = '0;
    logic [31:0] in_src1_data = '0;
    logic        in_src1_valid = 1'b0;
    logic [2:0]  in_src2_tag = '0;
    logic [31:0] in_src2_data = '0;
    logic        in_src2_valid = 1'b0;
    logic [2:0]  in_rd_tag = '0;
    logic [1:0]  cdb_valid = '0;
    logic [5:0]  cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [6:0]  issue_op;
    logic [2:0]  issue_funct3;
    logic [6:0]  issue_funct7;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic [2:0]  issue_rd_tag;
    logic [2:0]  count;

    int pass_cnt = 0;
    int total_cnt = 0;

    res_station_multi #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .TAG_W(3), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_src1_tag(in_src1_tag), .in_src1_data(in_src1_data), .in_src1_valid(in_src1_valid),
        .in_src2_tag(in_src2_tag), .in_src2_data(in_src2_data), .in_src2_valid(in_src2_valid),
        .in_rd_tag(in_rd_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_rd_tag(issue_rd_tag),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: slots with an allocation sequence number instead of any age structure
    bit          m_v   [DEPTH];
    int          m_seq [DEPTH];
    logic [6:0]  m_op  [DEPTH];
    logic [2:0]  m_f3  [DEPTH];
    logic [6:0]  m_f7  [DEPTH];
    logic [2:0]  m_t1  [DEPTH];
    logic [2:0]  m_t2  [DEPTH];
    logic [31:0] m_d1  [DEPTH];
    logic [31:0] m_d2  [DEPTH];
    bit          m_r1  [DEPTH];
    bit          m_r2  [DEPTH];
    logic [2:0]  m_rd  [DEPTH];
    int          next_seq = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_v[i]) n++;
        return n;
    endfunction

    function automatic int m_sel();
        int s = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_ORDER_EN
                if (s < 0 || m_seq[i] < m_seq[s]) s = i;
`else
                if (s < 0) s = i;
`endif
            end
        end
        return s;
    endfunction

    function automatic bit cdb_hit(input logic [2:0] tag, output logic [31:0] d);
        d = '0;
        for (int p = 0; p < NCDB; p++) begin
            if (cdb_valid[p] && cdb_tag[p*3 +: 3] == tag) begin
                d = cdb_data[p*32 +: 32];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
        end else begin
            int s, fr;
            bit al;
            logic [31:0] d;
            s  = m_sel();
            fr = -1;
            for (int i = 0; i < DEPTH; i++) if (!m_v[i] && fr < 0) fr = i;
            al = in_valid && (m_count() < DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                if (m_v[i] && !m_r1[i] && cdb_hit(m_t1[i], d)) begin m_r1[i] = 1'b1; m_d1[i] = d; end
                if (m_v[i] && !m_r2[i] && cdb_hit(m_t2[i], d)) begin m_r2[i] = 1'b1; m_d2[i] = d; end
            end
            if (s >= 0 && issue_ready) m_v[s] = 1'b0;
            if (al) begin
                m_v[fr] = 1'b1; m_seq[fr] = next_seq++;
                m_op[fr] = in_op; m_f3[fr] = in_funct3; m_f7[fr] = in_funct7; m_rd[fr] = in_rd_tag;
                m_t1[fr] = in_src1_tag; m_t2[fr] = in_src2_tag;
                m_r1[fr] = in_src1_valid; m_d1[fr] = in_src1_data;
                m_r2[fr] = in_src2_valid; m_d2[fr] = in_src2_data;
                if (!in_src1_valid && cdb_hit(in_src1_tag, d)) begin m_r1[fr] = 1'b1; m_d1[fr] = d; end
                if (!in_src2_valid && cdb_hit(in_src2_tag, d)) begin m_r2[fr] = 1'b1; m_d2[fr] = d; end
            end
            if (flush) for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        int s, n;
        s = m_sel();
        n = m_count();
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'(n < DEPTH));
        chk("issue_valid", 64'(issue_valid), 64'(s >= 0));
        if (s >= 0) begin
            chk("issue_rd_tag", 64'(issue_rd_tag), 64'(m_rd[s]));
            chk("issue_src1", 64'(issue_src1), 64'(m_d1[s]));
            chk("issue_src2", 64'(issue_src2), 64'(m_d2[s]));
            chk("issue_op", 64'({issue_op, issue_funct3, issue_funct7}), 64'({m_op[s], m_f3[s], m_f7[s]}));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] rd, input logic [2:0] t1, input logic [31:0] d1, input logic v1,
                          input logic [2:0] t2, input logic [31:0] d2, input logic v2);
        in_valid = 1'b1; in_op = 7'h33; in_funct3 = rd; in_funct7 = {4'h0, rd};
        in_rd_tag = rd; in_src1_tag = t1; in_src1_data = d1; in_src1_valid = v1;
        in_src2_tag = t2; in_src2_data = d2; in_src2_valid = v2;
    endtask

    task automatic alloc(input logic [2:0] rd, input logic [2:0] t1, input logic [31:0] d1, input logic v1,
                         input logic [2:0] t2, input logic [31:0] d2, input logic v2);
        set_in(rd, t1, d1, v1, t2, d2, v2);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic bcast(input logic [1:0] v, input logic [2:0] t0, input logic [31:0] d0,
                         input logic [2:0] t1, input logic [31:0] d1);
        cdb_valid = v; cdb_tag = {t1, t0}; cdb_data = {d1, d0};
    endtask

    logic [2:0] exp_ord [4];

    initial begin
`ifdef RS_AGE_ORDER_EN
        exp_ord[0] = 3'd5; exp_ord[1] = 3'd6; exp_ord[2] = 3'd7; exp_ord[3] = 3'd0;
`else
        exp_ord[0] = 3'd0; exp_ord[1] = 3'd5; exp_ord[2] = 3'd6; exp_ord[3] = 3'd7;
`endif
        #1;
        cyc(); cyc();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_issue_data", 64'({issue_src1, issue_src2}), 64'd0);
        reset_n = 1'b1;
        cyc();

        // Valid operands issue one cycle after allocation
        issue_ready = 1'b1;
        alloc(3'd1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd3, 1'b1);
        chk("t2_valid", 64'(issue_valid), 64'd1);
        chk("t2_src1", 64'(issue_src1), 64'd5);
        chk("t2_src2", 64'(issue_src2), 64'd3);
        chk("t2_rd", 64'(issue_rd_tag), 64'd1);
        cyc();
        chk("t2_count", 64'(count), 64'd0);

        // Wakeup from CDB port 1
        alloc(3'd2, 3'd2, 32'd0, 1'b0, 3'd0, 32'd9, 1'b1);
        chk("t3_wait", 64'(issue_valid), 64'd0);
        bcast(2'b10, 3'd0, 32'h1111, 3'd2, 32'h600d600d);
        cyc();
        bcast(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        chk("t3_src1", 64'(issue_src1), 64'h600d600d);
        cyc();

        // Same-cycle bypass, both ports match: port 0 wins
        bcast(2'b11, 3'd4, 32'd7, 3'd4, 32'd8);
        alloc(3'd3, 3'd0, 32'd1, 1'b1, 3'd4, 32'd0, 1'b0);
        bcast(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        chk("t4_valid", 64'(issue_valid), 64'd1);
        chk("t4_src2", 64'(issue_src2), 64'd7);
        cyc();

        // Alloc and issue in the same cycle keep count
        alloc(3'd1, 3'd0, 32'd10, 1'b1, 3'd0, 32'd11, 1'b1);
        alloc(3'd2, 3'd0, 32'd20, 1'b1, 3'd0, 32'd21, 1'b1);
        chk("t7_count", 64'(count), 64'd1);
        chk("t7_rd", 64'(issue_rd_tag), 64'd2);
        cyc();
        chk("t7_empty", 64'(count), 64'd0);

        // Fill, drop when full, reuse slot 0, then check issue order
        issue_ready = 1'b0;
        alloc(3'd4, 3'd1, 32'd0, 1'b0, 3'd0, 32'd40, 1'b1);
        alloc(3'd5, 3'd2, 32'd0, 1'b0, 3'd0, 32'd50, 1'b1);
        alloc(3'd6, 3'd3, 32'd0, 1'b0, 3'd0, 32'd60, 1'b1);
        alloc(3'd7, 3'd5, 32'd0, 1'b0, 3'd0, 32'd70, 1'b1);
        chk("t5_full_count", 64'(count), 64'd4);
        chk("t5_full_ready", 64'(in_ready), 64'd0);
        alloc(3'd3, 3'd0, 32'd1, 1'b1, 3'd0, 32'd2, 1'b1);
        chk("t5_drop", 64'(count), 64'd4);
        bcast(2'b01, 3'd1, 32'h101, 3'd0, 32'd0);
        cyc();
        bcast(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        chk("t5_slot0_rd", 64'(issue_rd_tag), 64'd4);
        issue_ready = 1'b1;
        cyc();
        issue_ready = 1'b0;
        chk("t5_after_issue", 64'(count), 64'd3);
        alloc(3'd0, 3'd6, 32'd0, 1'b0, 3'd0, 32'd80, 1'b1);
        bcast(2'b11, 3'd2, 32'h102, 3'd3, 32'h103);
        cyc();
        bcast(2'b11, 3'd5, 32'h105, 3'd6, 32'h106);
        cyc();
        bcast(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t5_order", 64'(issue_rd_tag), 64'(exp_ord[k]));
            cyc();
        end
        chk("t5_drained", 64'(count), 64'd0);

        // Flush drops resident entries and the same-cycle allocation
        alloc(3'd1, 3'd7, 32'd0, 1'b0, 3'd0, 32'd1, 1'b1);
        alloc(3'd2, 3'd7, 32'd0, 1'b0, 3'd0, 32'd1, 1'b1);
        alloc(3'd3, 3'd7, 32'd0, 1'b0, 3'd0, 32'd1, 1'b1);
        chk("t6_pre", 64'(count), 64'd3);
        flush = 1'b1;
        set_in(3'd2, 3'd0, 32'd1, 1'b1, 3'd0, 32'd2, 1'b1);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_valid", 64'(issue_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_no_issue", 64'(issue_valid), 64'd0);
        end

        // Asynchronous reset with 3 entries resident
        issue_ready = 1'b0;
        alloc(3'd1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1);
        alloc(3'd2, 3'd7, 32'd0, 1'b0, 3'd0, 32'd1, 1'b1);
        alloc(3'd3, 3'd7, 32'd0, 1'b0, 3'd0, 32'd1, 1'b1);
        chk("t1_pre", 64'(count), 64'd3);
        reset_n = 1'b0;
        #1;
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_valid", 64'(issue_valid), 64'd0);
        chk("t1_ready", 64'(in_ready), 64'd1);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("t1_after", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
